// File: rtl/irq_latch8.sv
// irq_latch8 -- eight-line interrupt request latch.
//   Synchronises raw request lines, captures rising edges into a pending
//   register and hands them one at a time (lowest enabled index first) to a
//   consumer over an irq/ack handshake, with per-line masking and sticky
//   overrun flags.
// Latency: req rising before edge E0 -> pending after E2 -> irq after E3.
// Backpressure: a request is held on irq/irq_id until ack; a one-cycle gap
//   with irq low always separates consecutive requests.
// Ports:
//   clk_i, reset_n_i   clock, asynchronous active-low reset
//   req_i[7:0]         raw (possibly asynchronous) request lines
//   mask_we_i/mask_in_i  mask register write strobe / value (1 = enabled)
//   ack_i              single-cycle acknowledge of the line on irq_id_o
//   clr_ovr_i          clear all overrun flags
//   pending_o[7:0]     latched edge events, regardless of mask
//   irq_o, irq_id_o    registered request and the index being requested
//   overrun_o[7:0]     sticky: edge arrived while the line was already pending
module irq_latch8 (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic [7:0] req_i,
  input  logic       mask_we_i,
  input  logic [7:0] mask_in_i,
  input  logic       ack_i,
  input  logic       clr_ovr_i,
  output logic [7:0] pending_o,
  output logic       irq_o,
  output logic [2:0] irq_id_o,
  output logic [7:0] overrun_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_e;

  logic [7:0] s1_q, s2_q, s3_q;
  logic [1:0] warm_q, warm_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] overrun_q, overrun_d;
  logic [7:0] mask_q, mask_d;
  state_e     state_q, state_d;
  logic [2:0] id_q, id_d;
  logic       irq_q, irq_d;

  logic [7:0] edge_det;
  logic [7:0] cand;
  logic       cand_any;
  logic [2:0] cand_id;
  logic       ack_fire;
  logic       withdraw;
  logic [7:0] ack_clr;

  // Synchroniser chain plus history flop. Everything clears on reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= req_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Warm-up: for the first three edges after reset the history flop has not
  // yet tracked a real synchronised sample, so a line already high at reset
  // release would look like a fresh edge. Edge detection stays disabled until
  // s3 holds a genuine copy of s2.
  always_comb begin
    warm_d = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
  end

  always_comb begin
    edge_det = (warm_q == 2'd3) ? (s2_q & ~s3_q) : 8'h00;
  end

  // Candidate selection: lowest enabled pending index.
  always_comb begin
    cand     = pending_q & mask_q;
    cand_any = |cand;
    cand_id  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cand[i]) cand_id = 3'(i);
    end
  end

  // Handshake events in ASSERT. Ack takes precedence over withdrawal.
  always_comb begin
    ack_fire = (state_q == ST_ASSERT) && ack_i;
    withdraw = (state_q == ST_ASSERT) && !ack_i && mask_we_i && !mask_in_i[id_q];
    ack_clr  = ack_fire ? (8'b1 << id_q) : 8'h00;
  end

  // Pending/overrun/mask next state. A new edge on the line being acked in
  // the same cycle wins: the bit stays set and this is not an overrun.
  always_comb begin
    pending_d = (pending_q & ~ack_clr) | edge_det;
    overrun_d = (clr_ovr_i ? 8'h00 : overrun_q) | (edge_det & pending_q & ~ack_clr);
    mask_d    = mask_we_i ? mask_in_i : mask_q;
  end

  // FSM: state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic. irq_id latches only on entry to ASSERT so it stays
  // stable for the whole request even if a lower index becomes pending.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_any) begin
          state_d = ST_ASSERT;
          id_d    = cand_id;
        end
      end
      ST_ASSERT: begin
        if (ack_fire)      state_d = ST_GAP;
        else if (withdraw) state_d = ST_IDLE;
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: output logic. irq is computed from the next state and registered so
  // the output comes straight from a flop.
  always_comb begin
    irq_d = (state_d == ST_ASSERT);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      warm_q    <= 2'd0;
      pending_q <= '0;
      overrun_q <= '0;
      mask_q    <= '0;
      id_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      warm_q    <= warm_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      mask_q    <= mask_d;
      id_q      <= id_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    pending_o = pending_q;
    overrun_o = overrun_q;
    irq_o     = irq_q;
    irq_id_o  = id_q;
  end

endmodule

// File: tb/tb_irq_latch8.sv
module tb_irq_latch8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] req;
  logic       mask_we;
  logic [7:0] mask_in;
  logic       ack;
  logic       clr_ovr;
  logic [7:0] pending;
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] overrun;

  always #5 clk = ~clk;

  irq_latch8 dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .req_i     (req),
    .mask_we_i (mask_we),
    .mask_in_i (mask_in),
    .ack_i     (ack),
    .clr_ovr_i (clr_ovr),
    .pending_o (pending),
    .irq_o     (irq),
    .irq_id_o  (irq_id),
    .overrun_o (overrun)
  );

  typedef struct packed {
    logic [7:0] pend;
    logic       irq;
    logic [2:0] id;
    logic [7:0] ovr;
  } obs_t;

  obs_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: request history as a list of recent samples, phases
  // named by number (0 idle, 1 requesting, 2 gap).
  bit [7:0] hist[3];
  int       since_rst;
  bit [7:0] m_pend, m_ovr, m_mask;
  int       m_ph;
  int       m_id;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) hist[i] = 8'h00;
    since_rst = 0;
    m_pend = 0; m_ovr = 0; m_mask = 0; m_ph = 0; m_id = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs the DUT sampled.
  task automatic model_step();
    bit [7:0] ev, clr_v, cand;
    int nph;
    obs_t o;
    if (!reset_n) begin
      model_reset();
    end else begin
      ev    = (since_rst >= 3) ? (hist[1] & ~hist[2]) : 8'h00;
      clr_v = (m_ph == 1 && ack) ? 8'(1 << m_id) : 8'h00;
      cand  = m_pend & m_mask;
      m_ovr = (clr_ovr ? 8'h00 : m_ovr) | (ev & m_pend & ~clr_v);
      m_pend = (m_pend & ~clr_v) | ev;
      nph = m_ph;
      if (m_ph == 0) begin
        if (cand != 0) begin m_id = lowest(cand); nph = 1; end
      end else if (m_ph == 1) begin
        if (ack) nph = 2;
        else if (mask_we && !mask_in[m_id]) nph = 0;
      end else begin
        nph = 0;
      end
      m_ph = nph;
      if (mask_we) m_mask = mask_in;
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = req;
      if (since_rst < 3) since_rst++;
    end
    o.pend = m_pend;
    o.irq  = (m_ph == 1);
    o.id   = 3'(m_id);
    o.ovr  = m_ovr;
    expq.push_back(o);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  // Monitor: every cycle the DUT presents its registered outputs; compare
  // against the oldest expectation.
  always @(negedge clk) begin
    obs_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("sb_pending", int'(pending), int'(e.pend));
      chk("sb_irq",     int'(irq),     int'(e.irq));
      if (e.irq) chk("sb_irq_id", int'(irq_id), int'(e.id));
      chk("sb_overrun", int'(overrun), int'(e.ovr));
    end
  end

  initial begin
    reset_n = 1'b0; req = 0; mask_we = 0; mask_in = 0; ack = 0; clr_ovr = 0;
    model_reset();
    ticks(2);
    look();
    chk("reset_pending", int'(pending), 0);
    chk("reset_irq", int'(irq), 0);
    chk("reset_irq_id", int'(irq_id), 0);
    chk("reset_overrun", int'(overrun), 0);
    reset_n = 1'b1;

    // Single event on line 5.
    mask_we = 1; mask_in = 8'hFF; tick(); mask_we = 0;
    ticks(2);
    req[5] = 1'b1;
    ticks(3); req[5] = 1'b0;
    look(); chk("single_pend_E2", int'(pending), 8'h20);
    tick();
    look(); chk("single_irq_E3", int'(irq), 1); chk("single_id_E3", int'(irq_id), 5);
    ack = 1; tick();
    look(); chk("single_pend_ack", int'(pending), 0); chk("single_irq_ack", int'(irq), 0);
    tick(); ack = 0;                                 // ack during GAP is ignored
    look(); chk("gap_ack_irq", int'(irq), 0); chk("gap_ack_id", int'(irq_id), 5);
    ack = 1; tick(); ack = 0; tick();                // ack during IDLE is ignored
    look(); chk("idle_ack_id", int'(irq_id), 5); chk("idle_ack_pend", int'(pending), 0);

    // Priority and stability.
    req[6] = 1; ticks(4);
    look(); chk("prio_id6", int'(irq_id), 6); chk("prio_pend40", int'(pending), 8'h40);
    req[1] = 1; ticks(3);
    look(); chk("prio_pend42", int'(pending), 8'h42); chk("prio_id_stable", int'(irq_id), 6);
    ack = 1; tick(); ack = 0;
    look(); chk("prio_pend02", int'(pending), 8'h02);
    ticks(2);
    look(); chk("prio_irq1", int'(irq), 1); chk("prio_id1", int'(irq_id), 1);
    ack = 1; tick(); ack = 0;
    look(); chk("prio_pend00", int'(pending), 0);
    req = 0; ticks(4);

    // Masking and withdrawal.
    mask_we = 1; mask_in = 8'h00; tick(); mask_we = 0;
    req[3] = 1; ticks(5); req[3] = 0;
    look(); chk("mask_pend08", int'(pending), 8'h08); chk("mask_irq0", int'(irq), 0);
    mask_we = 1; mask_in = 8'h08; tick(); mask_we = 0; tick();
    look(); chk("unmask_irq", int'(irq), 1); chk("unmask_id", int'(irq_id), 3);
    mask_we = 1; mask_in = 8'h00; tick(); mask_we = 0;
    look(); chk("withdraw_irq", int'(irq), 0); chk("withdraw_pend", int'(pending), 8'h08);
    ticks(2);

    // Overrun on line 0, then clear.
    req[0] = 1; ticks(3); req[0] = 0; ticks(3);
    req[0] = 1; ticks(3); req[0] = 0; ticks(2);
    look(); chk("ovr_set", int'(overrun), 8'h01); chk("ovr_pend", int'(pending), 8'h09);
    clr_ovr = 1; tick(); clr_ovr = 0;
    look(); chk("ovr_clr", int'(overrun), 0);

    // Edge on line 0 coinciding with its ack.
    mask_we = 1; mask_in = 8'h01; tick(); mask_we = 0; ticks(2);
    look(); chk("coll_irq", int'(irq), 1); chk("coll_id", int'(irq_id), 0);
    req[0] = 1; ticks(2);
    ack = 1; tick(); ack = 0;
    look(); chk("coll_pend", int'(pending), 8'h09); chk("coll_ovr", int'(overrun), 0);
    ticks(2); ack = 1; tick(); ack = 0; req[0] = 0;
    look(); chk("coll_redeliver", int'(pending), 8'h08);
    ticks(3);

    // Reset mid-handshake with all lines pending.
    mask_we = 1; mask_in = 8'h00; tick(); mask_we = 0;
    req = 8'hFF; ticks(4);
    look(); chk("all_pend", int'(pending), 8'hFF);
    mask_we = 1; mask_in = 8'hFF; tick(); mask_we = 0; tick();
    look(); chk("all_irq", int'(irq), 1);
    reset_n = 0;
    #1;
    chk("arst_pending", int'(pending), 0);
    chk("arst_irq", int'(irq), 0);
    chk("arst_id", int'(irq_id), 0);
    chk("arst_overrun", int'(overrun), 0);
    model_reset();
    ticks(2); reset_n = 1; ticks(8);
    look(); chk("held_req_no_edge", int'(pending), 0);
    req = 0; ticks(4);

    // Randomised traffic with the bench as consumer.
    mask_we = 1; mask_in = 8'($urandom); tick(); mask_we = 0;
    for (int n = 0; n < 3000; n++) begin
      req     = req ^ 8'($urandom & $urandom & $urandom);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_in = 8'($urandom);
      clr_ovr = ($urandom_range(0, 31) == 0);
      ack     = (m_ph == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      tick();
    end
    ack = 0; mask_we = 0; clr_ovr = 0;
    look();
    chk("queue_drained", expq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_latch8.md
# irq_latch8

Eight-line interrupt request latch: synchronises eight raw request lines, detects rising edges, holds them in a pending register and delivers them one at a time to a consumer through an irq/ack handshake. The `pending` output is the 8-bit vector that drives the downstream eight-input OR gate, whose output is the combined "anything pending" status. The block adds per-line masking, lowest-index priority selection and sticky overrun flags.

## Interface
- No parameters; fixed at 8 lines.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  raw request lines, may be asynchronous to `clk`.
- `mask_we`  in  1  load `mask_in` into the mask register this cycle.
- `mask_in`  in  8  new mask value; 1 = line enabled.
- `ack`  in  1  single-cycle acknowledge of the line currently on `irq_id`.
- `clr_ovr`  in  1  clear all overrun flags.
- `pending`  out  8  latched edge events, one bit per line, regardless of mask.
- `irq`  out  1  registered interrupt request to the consumer.
- `irq_id`  out  3  index of the line being requested; valid while `irq`=1.
- `overrun`  out  8  sticky per-line flag: edge arrived while already pending.

## Operation
- Per line: two-flop synchroniser (s1, s2), then a history flop s3. `edge[i] = s2[i] & ~s3[i]`.
- Pending register: `edge[i]` sets `pending[i]`. Mask does not block capture; masked events are delivered once unmasked.
- Overrun: `edge[i]` while `pending[i]`=1 (and not cleared in the same cycle) sets `overrun[i]`. Sticky until `clr_ovr`. If `clr_ovr` and a new overrun occur in the same cycle, set wins.
- Mask register: loaded from `mask_in` when `mask_we`=1. Reset value 0x00, all lines disabled.
- Candidate set: `pending & mask`. Selection: lowest set index.
- FSM:
  - IDLE: `irq`=0. If the candidate set is non-empty, latch the lowest index into `irq_id` and go to ASSERT.
  - ASSERT: `irq`=1, `irq_id` held stable even if a lower-index line becomes pending.
    - `ack`=1: clear `pending[irq_id]` and go to GAP.
    - Latched line masked (by `mask_we`) with no `ack`: withdraw, go to IDLE; `pending` bit retained.
    - `ack` and withdrawal in the same cycle: `ack` wins.
  - GAP: `irq`=0 for exactly one cycle, then IDLE. Guarantees the consumer sees a deassertion between requests.
- `ack` in IDLE or GAP is ignored; no register changes.
- Same cycle as `ack` clears bit i, with `edge[i]`=1: set wins. `pending[i]` stays 1 and no overrun is flagged; the new event is not lost.
- Reset (asynchronous, any time, including mid-handshake): s1/s2/s3, `pending`, `overrun` and mask = 0. FSM goes to IDLE, `irq`=0, `irq_id`=0. A `req` already high at reset release produces no edge until it falls and rises again, because s3 is loaded from s2 on the first edges.

## Timing
- `req[i]` rises before edge E0. Then:
  - s1=1 after E0, s2=1 after E1.
  - `pending[i]`=1 after E2.
  - FSM enters ASSERT and `irq`=1 after E3.
- Total latency from `req` to `irq`: 4 clock edges.
- From `ack` sampled at edge A: `pending` bit clears and `irq`=0 after A. GAP occupies A to A+1. The next candidate can assert `irq` after A+2.
- Throughput: at most one interrupt per 3 cycles when `ack` is given on the first ASSERT cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then single event:
  - Stimulus: `reset_n` low with all outputs 0, then high; mask=0xFF; pulse `req[5]` high for 3 cycles.
  - Required: `pending`=0x20 after E2; `irq`=1 with `irq_id`=5 after E3; `ack` at E4; `pending`=0x00 and `irq`=0 after E4.
- Priority and stability:
  - Stimulus: `req[6]` edge; while in ASSERT with id 6, raise `req[1]`.
  - Required: `irq_id` stays 6 until `ack`; after GAP, `irq_id`=1; `pending` goes 0x40 → 0x42 → 0x02 → 0x00.
- Masking:
  - Stimulus: mask=0x00; edge on `req[3]`.
  - Required: `pending`=0x08, `irq` stays 0. Write mask=0x08: `irq`=1, `irq_id`=3 two edges later.
  - Stimulus: in ASSERT, write mask=0x00.
  - Required: `irq` drops, `pending` stays 0x08.
- Overrun and same-cycle collision:
  - Stimulus: two edges on `req[0]` with no `ack`.
  - Required: `overrun`=0x01; `clr_ovr` returns it to 0x00.
  - Stimulus: time `edge[0]` to coincide with `ack` on line 0.
  - Required: `pending[0]`=1 remains and `overrun` stays 0x00.
- Reset mid-handshake:
  - Stimulus: assert `reset_n`=0 asynchronously while in ASSERT with `pending`=0xFF.
  - Required: all outputs 0 immediately. With `req` held high through release, `pending` stays 0x00.
- Spurious ack:
  - Stimulus: pulse `ack` in IDLE and in GAP.
  - Required: `pending`, `irq` and `irq_id` unchanged.
